muldiv_unit: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Sits beside the ALU in the execute stage and takes the same x/y operands from the register file.
- Its HI/LO outputs go to the writeback mux, which uses them for MFHI/MFLO.
- Its busy output goes to control, which stalls the PC while an operation runs.

---
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, both over
// unsigned magnitudes with one iteration per clock. Signs are fixed up in a
// final FIX cycle. MTHI/MTLO write HI/LO directly from IDLE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               is_div_reg, is_div_next;
  logic               neg_q_reg, neg_q_next;   // negate product / quotient
  logic               neg_r_reg, neg_r_next;   // negate remainder (dividend sign)
  logic               div0_reg, div0_next;     // divisor was zero
  logic [WIDTH-1:0]   x_reg, x_next;           // original dividend for y=0 case
  logic [WIDTH-1:0]   opd_reg, opd_next;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   acc_reg, acc_next;       // product high half / partial remainder
  logic [WIDTH-1:0]   quo_reg, quo_next;       // multiplier / dividend, becomes lo half / quotient
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  // Operand magnitudes for the signed ops; MULTU/DIVU pass raw operands.
  logic               op_signed;
  logic               sx, sy;
  logic [WIDTH-1:0]   ax, ay;

  assign op_signed = ~op[0];
  assign sx        = op_signed & x[WIDTH-1];
  assign sy        = op_signed & y[WIDTH-1];
  assign ax        = sx ? (~x + 1'b1) : x;
  assign ay        = sy ? (~y + 1'b1) : y;

  // One shift-add step: conditionally add, then shift {acc,quo} right.
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_reg} + (quo_reg[0] ? {1'b0, opd_reg} : {(WIDTH+1){1'b0}});

  // One restoring-division step: shift in next dividend bit, try to subtract.
  // When the subtraction succeeds the result fits in WIDTH bits, so the
  // modular low-half difference is exact.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  assign div_shift = {acc_reg, quo_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opd_reg};
  assign div_diff  = div_shift[WIDTH-1:0] - opd_reg;

  // Sign-corrected results used in FIX.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_raw = {acc_reg, quo_reg};
  assign prod_fix = neg_q_reg ? (~prod_raw + 1'b1) : prod_raw;
  assign quo_fix  = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign rem_fix  = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;

  // Next-state and datapath control; every target defaults to hold.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    div0_next   = div0_reg;
    x_next      = x_reg;
    opd_next    = opd_reg;
    acc_next    = acc_reg;
    quo_next    = quo_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_next  = CALC;
              cnt_next    = '0;
              is_div_next = op[1];
              neg_q_next  = sx ^ sy;
              neg_r_next  = sx;
              div0_next   = (y == '0);
              x_next      = x;
              acc_next    = '0;
              if (op[1]) begin
                quo_next = ax;
                opd_next = ay;
              end else begin
                quo_next = ay;
                opd_next = ax;
              end
            end
            3'b100:  hi_next = x;
            3'b101:  lo_next = x;
            default: ;
          endcase
        end
      end

      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (is_div_reg) begin
            acc_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_next = mul_sum[WIDTH:1];
            quo_next = {mul_sum[0], quo_reg[WIDTH-1:1]};
          end
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_next = FIX;
          end
        end
      end

      FIX: begin
        state_next = IDLE;
        if (!flush) begin
          done_next = 1'b1;
          if (!is_div_reg) begin
            hi_next = prod_fix[2*WIDTH-1:WIDTH];
            lo_next = prod_fix[WIDTH-1:0];
          end else if (div0_reg) begin
            hi_next = x_reg;
            lo_next = '1;
          end else begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      x_reg      <= '0;
      opd_reg    <= '0;
      acc_reg    <= '0;
      quo_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      div0_reg   <= div0_next;
      x_reg      <= x_next;
      opd_reg    <= opd_next;
      acc_reg    <= acc_next;
      quo_reg    <= quo_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a table of directed vectors with
// hand-computed HI/LO plus hand-written handshake/reset/flush sequences.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat = edges after E0.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    logic [W-1:0] save_hi, save_lo;

    vecs[0]  = '{3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'b001, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{3'b011, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E};
    vecs[8]  = '{3'b010, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[9]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; x = '0; y = '0;
    #12;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven MULT/MULTU/DIV/DIVU vectors.
    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), W'(lat), W + 1);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo, vecs[i].elo);
      chk($sformatf("vec%0d_busy_at_done", i), {31'b0, busy}, 0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), {31'b0, done}, 0);
      $display("vec %0d op=%b x=%h y=%h -> hi=%h lo=%h lat=%0d", i, vecs[i].op,
               vecs[i].a, vecs[i].b, hi, lo, lat);
    end

    // start held high through a MULT, operands changed mid-run.
    @(negedge clk);
    start = 1'b1; op = 3'b000; x = 32'hFFFFFFFD; y = 32'h00000007;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    x = 32'h00012345; y = 32'h000003E7; op = 3'b011;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("held_start_done", {31'b0, done}, 1);
    chk("held_start_hi", hi, 32'hFFFFFFFF);
    chk("held_start_lo", lo, 32'hFFFFFFEB);
    @(posedge clk); #1;
    chk("held_start_idle_after", {31'b0, busy}, 0);
    $display("held-start MULT -> hi=%h lo=%h", hi, lo);

    // flush at cycle 5 of a DIV.
    save_hi = hi; save_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 3'b010; x = 32'd100; y = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_busy", {31'b0, busy}, 0);
    @(negedge clk);
    flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("flush_no_done", W'(pulses), 0);
    chk("flush_hi_kept", hi, save_hi);
    chk("flush_lo_kept", lo, save_lo);
    $display("flush DIV -> hi=%h lo=%h done_pulses=%0d", hi, lo, pulses);

    // flush wins over start in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b000; x = 32'd5; y = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", {31'b0, busy}, 0);
    $display("flush+start in IDLE -> busy=%0b", busy);

    // MTHI / MTLO / no-op.
    @(negedge clk);
    start = 1'b1; op = 3'b100; x = 32'hA5A5A5A5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'hA5A5A5A5);
    chk("mthi_lo_kept", lo, save_lo);
    chk("mthi_busy", {31'b0, busy}, 0);
    chk("mthi_done", {31'b0, done}, 0);
    $display("MTHI -> hi=%h busy=%0b", hi, busy);
    @(negedge clk);
    start = 1'b1; op = 3'b101; x = 32'h5A5A0000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h5A5A0000);
    chk("mtlo_hi_kept", hi, 32'hA5A5A5A5);
    $display("MTLO -> lo=%h", lo);
    @(negedge clk);
    start = 1'b1; op = 3'b110; x = 32'h00000000;
    @(posedge clk); #1;
    start = 1'b0;
    chk("noop_hi", hi, 32'hA5A5A5A5);
    chk("noop_lo", lo, 32'h5A5A0000);
    chk("noop_busy", {31'b0, busy}, 0);
    $display("op 110 -> hi=%h lo=%h", hi, lo);

    // Asynchronous reset at cycle 10 of a MULT.
    @(negedge clk);
    start = 1'b1; op = 3'b000; x = 32'd3; y = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_busy", {31'b0, busy}, 0);
    $display("async reset mid-CALC -> hi=%h lo=%h busy=%0b", hi, lo, busy);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b001, 32'd3, 32'd4, lat);
    chk("post_rst_latency", W'(lat), W + 1);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 32'd12);
    $display("MULTU after reset -> hi=%h lo=%h lat=%0d", hi, lo, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
